// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised register file with one write port and NUM_RD
// asynchronous read ports. Entry 0 always reads as zero. After reset or a
// clr_req pulse, a clear engine zeroes one entry per cycle while init_busy
// is high. During that time all reads return zero and writes are dropped.
//
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a write that
// takes effect on the next edge is forwarded combinationally to any read
// port that addresses the same register (write-before-read).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   clr_req      one-cycle pulse; restarts the clear sequence
//   rg_wrt_en    write enable
//   rg_wrt_addr  write address
//   rg_wrt_data  write data
//   rg_rd_addr   packed read addresses; port k = [k*ADDR_W +: ADDR_W]
//   rg_rd_data   packed read data;      port k = [k*DATA_W +: DATA_W]
//   init_busy    high while the clear sequence is running
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_req,
  input  logic                       rg_wrt_en,
  input  logic [ADDR_W-1:0]          rg_wrt_addr,
  input  logic [DATA_W-1:0]          rg_wrt_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rg_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rg_rd_data,
  output logic                       init_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              user_wr;

  // A user write lands only in READY with reset released; address 0 is never stored.
  assign user_wr = reset && (state == READY) && rg_wrt_en && (rg_wrt_addr != '0);

  // The clear engine and the user share a single physical write port so the
  // array stays a plain one-write-port RAM.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rg_wrt_addr;
    mem_wdata = rg_wrt_data;
    if (reset && (state == CLEAR) && !clr_req) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (clr_req) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state <= READY;
      end
    end
  end

  assign init_busy = (state == CLEAR);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rg_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rg_rd_data[k*DATA_W +: DATA_W] = mem[ra];
      if (init_busy || (ra == '0)) begin
        rg_rd_data[k*DATA_W +: DATA_W] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (user_wr && (ra == rg_wrt_addr)) begin
        rg_rd_data[k*DATA_W +: DATA_W] = rg_wrt_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp. It runs a default
// instance (32x32, 2 read ports) and a 16x64 instance with 4 read ports.
// Expected values come from constant tables, from hand sequences, and from
// a behavioural model: each clear zeroes the whole array and then keeps the
// design busy for DEPTH cycles.
module tb_regfile_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance.
  logic        reset = 1'b0;
  logic        clr_req = 1'b0;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  ra0 = '0, ra1 = '0;
  logic [63:0] rdata;
  logic        busy;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .rg_wrt_en(wen), .rg_wrt_addr(waddr), .rg_wrt_data(wdata),
    .rg_rd_addr({ra1, ra0}), .rg_rd_data(rdata), .init_busy(busy)
  );

  // Wide instance.
  logic         reset2 = 1'b0;
  logic         clr2 = 1'b0;
  logic         wen2 = 1'b0;
  logic [3:0]   waddr2 = '0;
  logic [63:0]  wdata2 = '0;
  logic [15:0]  raddr2 = '0;
  logic [255:0] rdata2;
  logic         busy2;

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) dut2 (
    .clk(clk), .reset(reset2), .clr_req(clr2),
    .rg_wrt_en(wen2), .rg_wrt_addr(waddr2), .rg_wrt_data(wdata2),
    .rg_rd_addr(raddr2), .rg_rd_data(rdata2), .init_busy(busy2)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the default instance.
  logic [31:0] m [32];
  int unsigned busy_left = 32;

  function automatic logic [31:0] mrd(input logic [4:0] a);
    if (busy_left != 0 || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wen && reset && a == waddr) return wdata;
`endif
    return m[a];
  endfunction

  task automatic model_edge();
    if (!reset || clr_req) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      busy_left = 32;
    end else if (busy_left != 0) begin
      busy_left--;
    end else if (wen && waddr != 5'd0) begin
      m[waddr] = wdata;
    end
  endtask

  // Advance one clock: model follows the edge, inputs may change 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, {63'd0, busy_left != 0});
    chk({tag, "_rd0"}, {32'd0, rdata[31:0]}, {32'd0, mrd(ra0)});
    chk({tag, "_rd1"}, {32'd0, rdata[63:32]}, {32'd0, mrd(ra1)});
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5,  5'd3,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    tbl[5] = '{1'b1, 5'd5,  32'h00000001, 5'd31, 5'd6,  32'h12345678, 32'h0};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h00000001, 32'h00000001};

    // Reset held for 3 cycles, then exactly 32 busy cycles.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd1);
      cyc();
    end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      @(negedge clk);
      chk("clr_busy", {63'd0, busy}, 64'd1);
      chk("clr_rd0", {32'd0, rdata[31:0]}, 64'd0);
      cyc();
    end
    @(negedge clk);
    chk("clr_done", {63'd0, busy}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(a);
      #1;
      chk("init_rd0", {32'd0, rdata[31:0]}, 64'd0);
      chk("init_rd1", {32'd0, rdata[63:32]}, 64'd0);
    end
    cyc();

    // Constant vector table, from an all-zero READY array.
    for (int i = 0; i < 7; i++) begin
      wen = tbl[i].wen; waddr = tbl[i].wa; wdata = tbl[i].wd;
      ra0 = tbl[i].r0; ra1 = tbl[i].r1;
      @(negedge clk);
      chk("tbl_rd0", {32'd0, rdata[31:0]}, {32'd0, tbl[i].e0});
      chk("tbl_rd1", {32'd0, rdata[63:32]}, {32'd0, tbl[i].e1});
      cyc();
    end

    // Same-cycle write and read of x9.
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0000CAFE; ra0 = 5'd5; ra1 = 5'd9;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", {32'd0, rdata[63:32]}, 64'h0000CAFE);
`else
    chk("byp_same", {32'd0, rdata[63:32]}, 64'h0);
`endif
    chk("byp_other", {32'd0, rdata[31:0]}, 64'h1);
    cyc();
    wen = 1'b0;
    @(negedge clk);
    chk("byp_next", {32'd0, rdata[63:32]}, 64'h0000CAFE);
    cyc();

    // A write during the clear is dropped.
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; ra0 = 5'd7; ra1 = 5'd9;
    @(negedge clk);
    chk("busy_wr_busy", {63'd0, busy}, 64'd1);
    chk("busy_rd1", {32'd0, rdata[63:32]}, 64'd0);
    cyc();
    wen = 1'b0;
    for (int i = 0; i < 40 && busy_left != 0; i++) cyc();
    @(negedge clk);
    chk("busy_wr_done", {63'd0, busy}, 64'd0);
    chk("busy_wr_x7", {32'd0, rdata[31:0]}, 64'd0);
    cyc();

    // Fill x1..x31, clr_req, then reset at clr_cnt=10.
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 32'(i);
      cyc();
    end
    wen = 1'b0; ra0 = 5'd3; ra1 = 5'd20;
    @(negedge clk);
    chk("fill_x3", {32'd0, rdata[31:0]}, 64'd3);
    chk("fill_x20", {32'd0, rdata[63:32]}, 64'd20);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rs_busy", {63'd0, busy}, 64'd1);
      chk("rs_mask_x20", {32'd0, rdata[63:32]}, 64'd0);
      cyc();
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("rs_clr_busy", {63'd0, busy}, 64'd1);
      cyc();
    end
    @(negedge clk);
    chk("rs_done", {63'd0, busy}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      #1;
      chk("rs_zero0", {32'd0, rdata[31:0]}, 64'd0);
      chk("rs_zero1", {32'd0, rdata[63:32]}, 64'd0);
    end
    cyc();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 149) != 0);
      clr_req = ($urandom_range(0, 99) == 0);
      wen     = $urandom_range(0, 1)[0];
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      ra0     = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      ra1     = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      @(negedge clk);
      check_model("rnd");
      cyc();
    end
    reset = 1'b1; clr_req = 1'b0; wen = 1'b0;

    // Wide instance: 16-entry clear, then 4 ports on x1..x4.
    reset2 = 1'b0;
    cyc();
    reset2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("w_busy", {63'd0, busy2}, 64'd1);
      cyc();
    end
    @(negedge clk);
    chk("w_done", {63'd0, busy2}, 64'd0);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      wen2 = 1'b1; waddr2 = 4'(i); wdata2 = 64'h1_0000_0001 * 64'(i);
      cyc();
    end
    wen2 = 1'b0;
    raddr2 = {4'd4, 4'd3, 4'd2, 4'd1};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("w_port", rdata2[k*64 +: 64], 64'h1_0000_0001 * 64'(k + 1));
    end
    raddr2 = {4'd0, 4'd15, 4'd1, 4'd0};
    #1;
    chk("w_p0_x0", rdata2[63:0], 64'd0);
    chk("w_p1_x1", rdata2[127:64], 64'h1_0000_0001);
    chk("w_p2_x15", rdata2[191:128], 64'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
